// File: rtl/jhash_pkg.sv
// Shared types and constants for the lookup3 hash datapath.
package jhash_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SHIFT_W = 5;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [SHIFT_W-1:0] shift_t;

    // Per-call rotate amounts of one lookup3 mix() round, in call order.
    localparam shift_t MIX_SHIFTS [6] = '{
        shift_t'(4), shift_t'(6), shift_t'(8), shift_t'(16), shift_t'(19), shift_t'(4)
    };

endpackage

// File: rtl/jhash_mix_if.sv
// Operand/result bundle for one lookup3 mix step.
interface jhash_mix_if;
    import jhash_pkg::*;

    word_t  a;
    word_t  b;
    word_t  c;
    shift_t shift;
    word_t  OA;
    word_t  OB;
    word_t  OC;

    modport master (output a, b, c, shift, input OA, OB, OC);
    modport slave  (input a, b, c, shift, output OA, OB, OC);

endinterface

// File: rtl/jhash_rotl.sv
// Log-depth left barrel rotator; WIDTH must be a power of two.
module jhash_rotl #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [AMT_W+1];

    assign stage[0] = din;

    for (genvar i = 0; i < AMT_W; i++) begin : g_stage
        localparam int unsigned S = 1 << i;
        assign stage[i+1] = amt[i] ? {stage[i][WIDTH-1-S:0], stage[i][WIDTH-1:WIDTH-S]}
                                   : stage[i];
    end

    assign dout = stage[AMT_W];

endmodule

// File: rtl/jhash_mix.sv
// One lookup3 mix() step: OA=(a-c)^rotl(c,shift), OB=b, OC=c+b, optionally registered.
module jhash_mix
    import jhash_pkg::*;
#(
    parameter bit REGISTERED = 1'b0
) (
    input logic        clk,
    input logic        rst,
    jhash_mix_if.slave bus
);

    word_t rot_c;
    word_t oa_d;
    word_t oc_d;
    word_t oa_q;
    word_t ob_q;
    word_t oc_q;

    jhash_rotl #(
        .WIDTH (WORD_W)
    ) u_rotl (
        .din  (bus.c),
        .amt  (bus.shift),
        .dout (rot_c)
    );

    always_comb begin
        oa_d = (bus.a - bus.c) ^ rot_c;
        oc_d = bus.c + bus.b;
    end

    // Register stage always elaborated; unused copies are trimmed when REGISTERED=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oa_q <= '0;
            ob_q <= '0;
            oc_q <= '0;
        end else begin
            oa_q <= oa_d;
            ob_q <= bus.b;
            oc_q <= oc_d;
        end
    end

    assign bus.OA = REGISTERED ? oa_q : oa_d;
    assign bus.OB = REGISTERED ? ob_q : bus.b;
    assign bus.OC = REGISTERED ? oc_q : oc_d;

endmodule

// File: tb/tb_jhash_mix.sv
// Directed vectors, registered-mode reset sequences and a six-call lookup3 chain.
module tb_jhash_mix;

    logic clk;
    logic rst;

    int checks;
    int failures;

    jhash_mix_if bus_c ();
    jhash_mix_if bus_r ();

    jhash_mix #(.REGISTERED(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(bus_c));
    jhash_mix #(.REGISTERED(1'b1)) u_reg  (.clk(clk), .rst(rst), .bus(bus_r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [4:0]  shift;
        logic [31:0] oa;
        logic [31:0] ob;
        logic [31:0] oc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rot(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    task automatic ref_mix(inout logic [31:0] a, inout logic [31:0] b, inout logic [31:0] c);
        a = a - c; a = a ^ rot(c, 4);  c = c + b;
        b = b - a; b = b ^ rot(a, 6);  a = a + c;
        c = c - b; c = c ^ rot(b, 8);  b = b + a;
        a = a - c; a = a ^ rot(c, 16); c = c + b;
        b = b - a; b = b ^ rot(a, 19); a = a + c;
        c = c - b; c = c ^ rot(b, 4);  b = b + a;
    endtask

    task automatic drive_r(input vec_t v);
        bus_r.a = v.a; bus_r.b = v.b; bus_r.c = v.c; bus_r.shift = v.shift;
    endtask

    task automatic check_r(input string name, input logic [31:0] oa, input logic [31:0] ob,
                           input logic [31:0] oc);
        check({name, ".OA"}, bus_r.OA, oa);
        check({name, ".OB"}, bus_r.OB, ob);
        check({name, ".OC"}, bus_r.OC, oc);
    endtask

    initial begin
        logic [31:0] ma, mb, mc, da, db, dc, na, nb, nc;
        int shifts [6];

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        shifts   = '{4, 6, 8, 16, 19, 4};

        vecs[0] = '{32'h10, 32'h1, 32'h1, 5'd4, 32'h1F, 32'h1, 32'h2};
        vecs[1] = '{32'h0, 32'h80000000, 32'h80000000, 5'd1, 32'h80000001, 32'h80000000, 32'h0};
        vecs[2] = '{32'h5, 32'h7, 32'h3, 5'd0, 32'h1, 32'h7, 32'hA};
        vecs[3] = '{32'h1, 32'h0, 32'h1, 5'd31, 32'h80000000, 32'h0, 32'h1};
        vecs[4] = '{32'h12345678, 32'h0, 32'h12345678, 5'd16, 32'h56781234, 32'h0, 32'h12345678};
        vecs[5] = '{32'h0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
        vecs[6] = '{32'h0, 32'h0, 32'h00000003, 5'd31, 32'h7FFFFFFC, 32'h0, 32'h3};

        drive_r(vecs[0]);
        // Combinational DUT is exercised with rst held high: it must be unaffected.
        for (int i = 0; i < 7; i++) begin
            bus_c.a = vecs[i].a; bus_c.b = vecs[i].b;
            bus_c.c = vecs[i].c; bus_c.shift = vecs[i].shift;
            #1;
            check($sformatf("vec%0d.OA", i), bus_c.OA, vecs[i].oa);
            check($sformatf("vec%0d.OB", i), bus_c.OB, vecs[i].ob);
            check($sformatf("vec%0d.OC", i), bus_c.OC, vecs[i].oc);
        end

        // Registered mode: held in reset across edges with live inputs.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_r("reg_in_reset", 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_r("reg_after_release", 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_r("reg_first_capture", 32'h1F, 32'h1, 32'h2);
        drive_r(vecs[2]);
        @(posedge clk); #1;
        check_r("reg_second_capture", 32'h1, 32'h7, 32'hA);
        drive_r(vecs[4]);
        #2;
        check_r("reg_hold_between_edges", 32'h1, 32'h7, 32'hA);
        rst = 1'b1;
        #1;
        check_r("reg_async_reset", 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_r("reg_reset_over_edge", 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_r(vecs[1]);
        @(posedge clk); #1;
        check_r("reg_capture_after_rerelease", 32'h80000001, 32'h80000000, 32'h0);

        // Six chained calls with role rotation vs. software lookup3 mix().
        for (int t = 0; t < 4; t++) begin
            ma = $urandom; mb = $urandom; mc = $urandom;
            da = ma; db = mb; dc = mc;
            ref_mix(ma, mb, mc);
            for (int s = 0; s < 6; s++) begin
                bus_c.a = da; bus_c.b = db; bus_c.c = dc; bus_c.shift = 5'(shifts[s]);
                #1;
                na = bus_c.OB; nb = bus_c.OC; nc = bus_c.OA;
                da = na; db = nb; dc = nc;
            end
            check($sformatf("chain%0d.a", t), da, ma);
            check($sformatf("chain%0d.b", t), db, mb);
            check($sformatf("chain%0d.c", t), dc, mc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
